// File: rtl/c3lib_mtie_strap_cfg_if.sv
// Bundle of strap, software-write and status signals for c3lib_mtie_strap_cfg.
// cfg_par_err is present only when C3LIB_MTIE_PARITY_EN is defined.
interface c3lib_mtie_strap_cfg_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] strap_in;
    logic             sw_wr_en;
    logic [WIDTH-1:0] sw_wr_data;
    logic             sw_lock;
    logic [WIDTH-1:0] cfg_out;
    logic             cfg_vld;
    logic             sw_wr_ack;
    logic             sw_wr_nack;
    logic             locked;
`ifdef C3LIB_MTIE_PARITY_EN
    logic             cfg_par_err;
`endif

    modport master (
        output strap_in, sw_wr_en, sw_wr_data, sw_lock,
        input  cfg_out, cfg_vld, sw_wr_ack, sw_wr_nack, locked
`ifdef C3LIB_MTIE_PARITY_EN
        , input cfg_par_err
`endif
    );

    modport slave (
        input  strap_in, sw_wr_en, sw_wr_data, sw_lock,
        output cfg_out, cfg_vld, sw_wr_ack, sw_wr_nack, locked
`ifdef C3LIB_MTIE_PARITY_EN
        , output cfg_par_err
`endif
    );
endinterface

// File: rtl/c3lib_mtie_strap_cfg.sv
// Strap-captured configuration word with metal default, software override and sticky lock.
// Optional SEU parity check on the config flops: define C3LIB_MTIE_PARITY_EN.
//
// state      | meaning
// SETTLE     | counting down settle time after reset release
// CAPTURE    | one cycle: sample strap_in into masked bits
// ACTIVE     | config valid; software writes accepted until locked
module c3lib_mtie_strap_cfg #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] TIE_VAL    = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] STRAP_MASK = {WIDTH{1'b0}},
    parameter int               SETTLE_CYC = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    c3lib_mtie_strap_cfg_if.slave cfg_if
);
    typedef enum logic [1:0] {
        ST_SETTLE  = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_ACTIVE  = 2'd2
    } state_t;

    localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYC - 1);

    state_t           state_q, state_nxt;
    logic [7:0]       cnt_q;
    logic [WIDTH-1:0] cfg_q, cfg_nxt;
    logic             cfg_upd;
    logic             vld_q, ack_q, nack_q, locked_q;
    logic             wr_ok;
    logic             active;

    assign active = (state_q == ST_ACTIVE);
    assign wr_ok  = cfg_if.sw_wr_en & active & ~locked_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_SETTLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        cfg_nxt   = cfg_q;
        cfg_upd   = 1'b0;
        case (state_q)
            ST_SETTLE: begin
                if (cnt_q == 8'd0) state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                cfg_nxt   = (cfg_if.strap_in & STRAP_MASK) | (TIE_VAL & ~STRAP_MASK);
                cfg_upd   = 1'b1;
                state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (wr_ok) begin
                    cfg_nxt = cfg_if.sw_wr_data;
                    cfg_upd = 1'b1;
                end
            end
            default: state_nxt = ST_SETTLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= CNT_INIT;
            cfg_q    <= TIE_VAL;
            vld_q    <= 1'b0;
            ack_q    <= 1'b0;
            nack_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            // Counter reloads outside SETTLE so a recovery from an illegal state waits the full time.
            if (state_q == ST_SETTLE) begin
                if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
            end else begin
                cnt_q <= CNT_INIT;
            end
            cfg_q    <= cfg_nxt;
            vld_q    <= (state_nxt == ST_ACTIVE);
            ack_q    <= wr_ok;
            nack_q   <= cfg_if.sw_wr_en & ~wr_ok;
            locked_q <= locked_q | (cfg_if.sw_lock & active);
        end
    end

`ifdef C3LIB_MTIE_PARITY_EN
    logic par_q, par_err_q;

    // Parity is stored only on genuine updates so a flipped flop cannot refresh it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q     <= ^TIE_VAL;
            par_err_q <= 1'b0;
        end else begin
            if (cfg_upd) par_q <= ^cfg_nxt;
            par_err_q <= par_err_q | ((^cfg_q) != par_q);
        end
    end

    assign cfg_if.cfg_par_err = par_err_q;
`else
    logic unused_upd;
    assign unused_upd = cfg_upd;
`endif

    assign cfg_if.cfg_out    = cfg_q;
    assign cfg_if.cfg_vld    = vld_q;
    assign cfg_if.sw_wr_ack  = ack_q;
    assign cfg_if.sw_wr_nack = nack_q;
    assign cfg_if.locked     = locked_q;
endmodule

// File: tb/tb_c3lib_mtie_strap_cfg.sv
// Scoreboard bench for c3lib_mtie_strap_cfg: directed test-plan cases then randomized rounds.
module tb_c3lib_mtie_strap_cfg;
    localparam int         WIDTH  = 8;
    localparam logic [7:0] TIE    = 8'hFF;
    localparam logic [7:0] MASK   = 8'h0F;
    localparam int         SETTLE = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    c3lib_mtie_strap_cfg_if #(.WIDTH(WIDTH)) bus ();

    c3lib_mtie_strap_cfg #(
        .WIDTH(WIDTH), .TIE_VAL(TIE), .STRAP_MASK(MASK), .SETTLE_CYC(SETTLE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_if(bus.slave)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       ack;
        logic [7:0] cfg;
        logic       lck;
    } exp_t;
    exp_t sb[$];

    // Reference model: edges since reset release decide the phase; no state machine needed.
    int         edge_cnt = 0;
    logic [7:0] m_cfg = TIE;
    logic       m_locked = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic cyc(input logic en, input logic [7:0] d, input logic lk);
        exp_t e;
        bus.sw_wr_en   = en;
        bus.sw_wr_data = d;
        bus.sw_lock    = lk;
        @(posedge clk);
        edge_cnt++;
        if (edge_cnt == SETTLE + 1) m_cfg = (bus.strap_in & MASK) | (TIE & ~MASK);
        if (en) begin
            e.ack = (edge_cnt >= SETTLE + 2) && !m_locked;
            if (e.ack) m_cfg = d;
        end
        if (lk && edge_cnt >= SETTLE + 2) m_locked = 1'b1;
        if (en) begin
            e.cfg = m_cfg;
            e.lck = m_locked;
            sb.push_back(e);
        end
        #1;
        bus.sw_wr_en = 1'b0;
        bus.sw_lock  = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("cfg_out", bus.cfg_out, m_cfg);
            chk("cfg_vld", bus.cfg_vld, edge_cnt >= SETTLE + 1);
            chk("locked", bus.locked, m_locked);
            if (bus.sw_wr_ack && bus.sw_wr_nack) chk("ack_nack_excl", 1, 0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sw_wr_ack", bus.sw_wr_ack, e.ack);
                chk("sw_wr_nack", bus.sw_wr_nack, !e.ack);
                chk("resp_cfg", bus.cfg_out, e.cfg);
                chk("resp_locked", bus.locked, e.lck);
            end else begin
                chk("idle_pulse", {bus.sw_wr_ack, bus.sw_wr_nack}, 2'b00);
            end
        end
    end

    // Assert reset mid-cycle, check the immediate async values, then release between edges.
    task automatic mid_reset(input logic [7:0] new_strap);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_cfg_out", bus.cfg_out, TIE);
        chk("rst_cfg_vld", bus.cfg_vld, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_pulses", {bus.sw_wr_ack, bus.sw_wr_nack}, 2'b00);
`ifdef C3LIB_MTIE_PARITY_EN
        chk("rst_par_err", bus.cfg_par_err, 0);
`endif
        edge_cnt = 0;
        m_cfg    = TIE;
        m_locked = 1'b0;
        sb.delete();
        bus.strap_in = new_strap;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.strap_in   = 8'hA5;
        bus.sw_wr_en   = 1'b0;
        bus.sw_wr_data = 8'h00;
        bus.sw_lock    = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("init_cfg_out", bus.cfg_out, TIE);
        chk("init_cfg_vld", bus.cfg_vld, 0);
        rst_n = 1'b1;

        // Write during SETTLE is nacked; capture still yields F5.
        cyc(0, 8'h00, 0);
        cyc(1, 8'h11, 1);
        repeat (3) cyc(0, 8'h00, 0);
        chk("capture_val", bus.cfg_out, 8'hF5);
        cyc(1, 8'h3C, 0);
        chk("write_3c", bus.cfg_out, 8'h3C);

`ifdef C3LIB_MTIE_PARITY_EN
        begin
            logic [7:0] tmp;
            chk("par_err_after_write", bus.cfg_par_err, 0);
            tmp = dut.cfg_q;
            force dut.cfg_q = tmp ^ 8'h01;
            m_cfg = m_cfg ^ 8'h01;
            cyc(0, 8'h00, 0);
            release dut.cfg_q;
            chk("par_err_set", bus.cfg_par_err, 1);
            cyc(0, 8'h00, 0);
            chk("par_err_sticky", bus.cfg_par_err, 1);
        end
`endif

        cyc(1, 8'h12, 0);
        cyc(1, 8'h34, 0);
        cyc(1, 8'h77, 1);
        cyc(1, 8'h00, 0);
        cyc(0, 8'h00, 0);
        chk("locked_final", bus.cfg_out, 8'h77);

        mid_reset(8'hA5);
        repeat (6) cyc(0, 8'h00, 0);
        chk("recapture_val", bus.cfg_out, 8'hF5);

        for (int r = 0; r < 4; r++) begin
            mid_reset(8'($urandom));
            for (int i = 0; i < 40; i++)
                cyc($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 19) == 0);
        end

        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
